// File: rtl/countdown_controller.sv
// countdown_controller
// MM:SS BCD countdown sequencer for the Doomsday clock. It provides a set mode,
// countdown on the 1 Hz tick, pause/resume, and an expiry alarm with display blanking.
//
// Handshake note: there are no valid/ready channels here. Every control input
// is a one-clk-wide pulse that is sampled on a rising clk edge. Every output is
// a register whose new value is visible just after that edge.
//
// Per-cycle priority: reset > btn_clear > expiry > btn_pause > btn_start >
// tick/increments.

module countdown_controller #(
  parameter logic [3:0] PRESET_M10 = 4'd0,
  parameter logic [3:0] PRESET_M1  = 4'd5,
  parameter logic [3:0] PRESET_S10 = 4'd0,
  parameter logic [3:0] PRESET_S1  = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       btn_inc_min,
  input  logic       btn_inc_sec,
  output logic [3:0] bin3,
  output logic [3:0] bin2,
  output logic [3:0] bin1,
  output logic [3:0] bin0,
  output logic [1:0] state_o,
  output logic       running,
  output logic       expired,
  output logic       blank
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t     state_q;
  logic [3:0] m10_q, m1_q, s10_q, s1_q;
  logic       running_q, expired_q, blank_q;

  // Decremented time (one second less) and helper flags
  logic [3:0] dec_m10_d, dec_m1_d, dec_s10_d, dec_s1_d;
  logic       brw_s1, brw_s10, brw_m1;
  logic       dec_zero;
  logic       time_zero;

  // Incremented fields (each field wraps 59 -> 00 independently)
  logic [3:0] inc_m10_d, inc_m1_d, inc_s10_d, inc_s1_d;

  // BCD borrow chain for a one-second decrement of MM:SS
  always_comb begin
    brw_s1    = (s1_q == 4'd0);
    dec_s1_d  = brw_s1 ? 4'd9 : s1_q - 4'd1;

    brw_s10   = 1'b0;
    dec_s10_d = s10_q;
    if (brw_s1) begin
      brw_s10   = (s10_q == 4'd0);
      dec_s10_d = brw_s10 ? 4'd5 : s10_q - 4'd1;
    end

    brw_m1    = 1'b0;
    dec_m1_d  = m1_q;
    if (brw_s10) begin
      brw_m1   = (m1_q == 4'd0);
      dec_m1_d = brw_m1 ? 4'd9 : m1_q - 4'd1;
    end

    dec_m10_d = m10_q;
    if (brw_m1) begin
      dec_m10_d = m10_q - 4'd1;
    end

    dec_zero  = (dec_m10_d == 4'd0) && (dec_m1_d == 4'd0) &&
                (dec_s10_d == 4'd0) && (dec_s1_d == 4'd0);
    time_zero = (m10_q == 4'd0) && (m1_q == 4'd0) &&
                (s10_q == 4'd0) && (s1_q == 4'd0);
  end

  // Field increments used only in IDLE; no carry between fields
  always_comb begin
    inc_s1_d  = s1_q + 4'd1;
    inc_s10_d = s10_q;
    if (s1_q == 4'd9) begin
      inc_s1_d  = 4'd0;
      inc_s10_d = (s10_q == 4'd5) ? 4'd0 : s10_q + 4'd1;
    end

    inc_m1_d  = m1_q + 4'd1;
    inc_m10_d = m10_q;
    if (m1_q == 4'd9) begin
      inc_m1_d  = 4'd0;
      inc_m10_d = (m10_q == 4'd5) ? 4'd0 : m10_q + 4'd1;
    end
  end

  // Main sequencer: state, digits and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      m10_q     <= PRESET_M10;
      m1_q      <= PRESET_M1;
      s10_q     <= PRESET_S10;
      s1_q      <= PRESET_S1;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      blank_q   <= 1'b0;
    end else if (btn_clear) begin
      // Abort from any state: back to the preset, display un-blanked
      state_q   <= IDLE;
      m10_q     <= PRESET_M10;
      m1_q      <= PRESET_M1;
      s10_q     <= PRESET_S10;
      s1_q      <= PRESET_S1;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_start && !time_zero) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else begin
            // A start at 00:00 is ignored, so increments still apply
            if (btn_inc_min) begin
              m10_q <= inc_m10_d;
              m1_q  <= inc_m1_d;
            end
            if (btn_inc_sec) begin
              s10_q <= inc_s10_d;
              s1_q  <= inc_s1_d;
            end
          end
        end

        RUN: begin
          if (tick) begin
            m10_q <= dec_m10_d;
            m1_q  <= dec_m1_d;
            s10_q <= dec_s10_d;
            s1_q  <= dec_s1_d;
            if (dec_zero) begin
              // Expiry wins over a pause in the same cycle
              state_q   <= EXPIRED;
              running_q <= 1'b0;
              expired_q <= 1'b1;
              blank_q   <= 1'b0;
            end else if (btn_pause) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end
          end else if (btn_pause) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
        end

        PAUSE: begin
          // The tick is dropped, even when it coincides with the resume
          if (btn_start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end

        EXPIRED: begin
          // Digits stay at 00:00; blink the display on each tick
          if (tick) begin
            blank_q <= ~blank_q;
          end
        end

        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          expired_q <= 1'b0;
          blank_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bin3    = m10_q;
  assign bin2    = m1_q;
  assign bin1    = s10_q;
  assign bin0    = s1_q;
  assign state_o = state_q;
  assign running = running_q;
  assign expired = expired_q;
  assign blank   = blank_q;

endmodule

// File: doc/countdown_controller.md
Name: countdown_controller

Overview:
- Sequences the MM:SS BCD time datapath for the Doomsday clock: set mode, countdown on the 1 Hz tick, pause/resume, and expiry alarm.
- Replaces the free-running up-counter.
- Takes single-cycle pulses from the debounced button logic and the enable from clock_divider.
- Drives bin3..bin0 into SegDisplay, plus status flags for LEDs and display blanking.

Parameters:
- PRESET_M10, 0, preset tens-of-minutes digit (0-5)
- PRESET_M1, 5, preset minutes-units digit (0-9)
- PRESET_S10, 0, preset tens-of-seconds digit (0-5)
- PRESET_S1, 0, preset seconds-units digit (0-9); default preset 05:00

Ports:
- clk  input  1  system clock; single clock domain
- reset  input  1  asynchronous, active-high reset
- tick  input  1  one-clk-wide 1 Hz enable from clock_divider
- btn_start  input  1  one-clk pulse: start / resume
- btn_pause  input  1  one-clk pulse: pause
- btn_clear  input  1  one-clk pulse: abort and reload preset
- btn_inc_min  input  1  one-clk pulse: +1 minute (IDLE only)
- btn_inc_sec  input  1  one-clk pulse: +1 second (IDLE only)
- bin3  output  4  BCD tens of minutes (0-5)
- bin2  output  4  BCD minutes units (0-9)
- bin1  output  4  BCD tens of seconds (0-5)
- bin0  output  4  BCD seconds units (0-9)
- state_o  output  2  IDLE=0, RUN=1, PAUSE=2, EXPIRED=3
- running  output  1  high in RUN
- expired  output  1  high in EXPIRED
- blank  output  1  display blank request; toggles while expired

Behaviour:
- All outputs registered; an input sampled on edge N shows its effect after edge N.
- Reset (any time, including mid-countdown): state IDLE, bin3..bin0 = preset, running=0, expired=0, blank=0.
- Digits always hold legal BCD; the minute field and the second field each stay in 00-59.
- IDLE:
  - btn_inc_min: minutes field +1, 59 wraps to 00; seconds unchanged.
  - btn_inc_sec: seconds field +1, 59 wraps to 00; no carry into minutes.
  - Both pulses in the same cycle: both applied.
  - btn_start: enter RUN only if time != 00:00; at 00:00 it is ignored and the block stays IDLE.
  - btn_clear: reload preset.
  - tick and btn_pause: ignored.
- RUN:
  - On tick: BCD decrement of MM:SS. bin0 0 borrows to 9; bin1 0 borrows to 5; bin2 0 borrows to 9; bin3 decrements.
  - If the decrement yields 00:00, enter EXPIRED on the same edge.
  - btn_pause: enter PAUSE. If tick arrives in the same cycle, the decrement is still applied.
  - Expiry beats pause: 00:01 + tick + pause -> EXPIRED.
  - btn_inc_* and btn_start: ignored.
- PAUSE:
  - Digits hold; tick ignored.
  - btn_start: enter RUN. A tick in the same cycle is not applied.
  - btn_pause: no effect.
- EXPIRED:
  - Digits 00:00, expired=1.
  - blank toggles on every tick; starts at 0 on entry.
  - btn_start and btn_pause: ignored.
- btn_clear in RUN, PAUSE or EXPIRED: go to IDLE, reload preset, blank=0.
- Priority within a cycle: reset > btn_clear > expiry > btn_pause > btn_start > tick/increments.
- running = (state==RUN); expired = (state==EXPIRED).

Test Plan:
1. Reset, then btn_start, then 3 ticks -> digits 05:00 -> 04:59 -> 04:58 -> 04:57; running=1 after the start edge.
2. Set 00:02 in IDLE (btn_clear, then btn_inc_min until minutes=00 and btn_inc_sec until seconds=02); start; 2 ticks -> 00:01, then 00:00 with state_o=3 and expired=1. Next 3 ticks: blank 1,0,1. btn_clear -> 05:00, IDLE, blank=0.
3. RUN at 10:00, one tick -> 09:59. At 00:10, one tick -> 00:09 (borrow chain checked across every digit).
4. IDLE at 59:59: btn_inc_min -> 00:59; btn_inc_sec -> 00:00; btn_start at 00:00 -> stays IDLE.
5. RUN at 03:00: pause and tick in the same cycle -> 02:59 in PAUSE. Then 5 ticks -> still 02:59. Start and tick in the same cycle -> RUN, 02:59.
6. Assert reset asynchronously mid-RUN between clock edges -> outputs go to preset/IDLE immediately, with no clock edge needed.
